sd_cmd_sequencer: RTL and testbench

- Upstream stage of the SPI byte engine; CPU or boot logic issues a whole SD-card SPI-mode command as a single request.
- Frames the 6-byte command (start bits, index, 32-bit argument, CRC7, end bit) and pushes it byte-by-byte through the engine's byte handshake.
- Polls for the R1 response, clocks trailing idle bytes, drives chip-select and reports R1 or timeout.

---
 rtl/sd_spi_pkg.sv | 18 +
 rtl/crc7_byte.sv | 24 ++
 rtl/sd_cmd_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI-mode command path.
// Holds the sequencer state enum and the command framing constants.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    POLL,
    TRAIL,
    DONE
  } state_t;

  localparam logic [6:0] CRC7_POLY      = 7'h09;
  localparam logic [7:0] SD_IDLE_BYTE   = 8'hFF;
  localparam logic [1:0] CMD_START_BITS = 2'b01;
  localparam int         CMD_LEN        = 6;

endpackage

// File: rtl/crc7_byte.sv
// One-byte CRC7 (x^7+x^3+1) update, MSB-first, purely combinational.
// Ports: crc_in running CRC, data next byte, crc_out updated CRC.
module crc7_byte
  import sd_spi_pkg::*;
(
  input  logic [6:0] crc_in,
  input  logic [7:0] data,
  output logic [6:0] crc_out
);

  always_comb begin
    logic [6:0] w_c;
    logic       w_fb;
    w_c  = crc_in;
    w_fb = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      w_fb = w_c[6] ^ data[i];
      w_c  = {w_c[5:0], 1'b0};
      if (w_fb) w_c = w_c ^ CRC7_POLY;
    end
    crc_out = w_c;
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// Frames an SD SPI-mode command, polls R1, clocks trailing bytes.
// Ports: cmd_* request, resp_* result, cs_n, byte_* engine handshake.
module sd_cmd_sequencer
  import sd_spi_pkg::*;
#(
  parameter int POLL_MAX    = 8,
  parameter int TRAIL_BYTES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        busy,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic        resp_timeout,
  output logic        cs_n,
  output logic        byte_req,
  output logic        byte_wr,
  output logic [7:0]  byte_wdata,
  input  logic        byte_ack,
  input  logic [7:0]  byte_rdata
);

  state_t      r_state, w_state;
  logic [31:0] r_arg, w_arg;
  logic [2:0]  r_cnt, w_cnt;
  logic [6:0]  r_crc, w_crc;
  logic [7:0]  r_poll, w_poll;
  logic [3:0]  r_trail, w_trail;
  logic        r_req, w_req;
  logic        r_wr, w_wr;
  logic [7:0]  r_wdata, w_wdata;
  logic [7:0]  r_r1, w_r1;
  logic        r_to, w_to;

  logic        w_accept;
  logic        w_ack;
  logic [2:0]  w_cnt_nx;
  logic [7:0]  w_byte0;
  logic [7:0]  w_next_byte;
  logic [6:0]  w_crc_seed;
  logic [7:0]  w_crc_data;
  logic [6:0]  w_crc_step;
  state_t      w_post;

  assign w_accept = cmd_start &&
    (r_state == IDLE || r_state == DONE);
  assign w_ack    = byte_ack && r_req;
  assign w_cnt_nx = r_cnt + 3'd1;
  assign w_byte0  = {CMD_START_BITS, cmd_index};
  assign w_post   = (TRAIL_BYTES == 0) ? DONE : TRAIL;

  always_comb begin
    unique case (w_cnt_nx)
      3'd1:    w_next_byte = r_arg[31:24];
      3'd2:    w_next_byte = r_arg[23:16];
      3'd3:    w_next_byte = r_arg[15:8];
      3'd4:    w_next_byte = r_arg[7:0];
      default: w_next_byte = {r_crc, 1'b1};
    endcase
  end

  // Byte 0 seeds from zero at accept; later bytes chain r_crc.
  assign w_crc_seed = w_accept ? 7'd0 : r_crc;
  assign w_crc_data = w_accept ? w_byte0 : w_next_byte;

  crc7_byte u_crc (
    .crc_in  (w_crc_seed),
    .data    (w_crc_data),
    .crc_out (w_crc_step)
  );

  always_comb begin
    w_state = r_state;
    w_arg   = r_arg;
    w_cnt   = r_cnt;
    w_crc   = r_crc;
    w_poll  = r_poll;
    w_trail = r_trail;
    w_req   = r_req;
    w_wr    = r_wr;
    w_wdata = r_wdata;
    w_r1    = r_r1;
    w_to    = r_to;
    unique case (r_state)
      IDLE, DONE: begin
        w_state = IDLE;
        if (w_accept) begin
          w_state = SEND;
          w_arg   = cmd_arg;
          w_cnt   = 3'd0;
          w_crc   = w_crc_step;
          w_req   = 1'b1;
          w_wr    = 1'b1;
          w_wdata = w_byte0;
          w_r1    = SD_IDLE_BYTE;
          w_to    = 1'b0;
        end
      end
      SEND: begin
        if (w_ack) begin
          w_req = 1'b0;
          if (r_cnt == 3'(CMD_LEN - 1)) begin
            w_state = POLL;
            w_wr    = 1'b0;
            w_wdata = SD_IDLE_BYTE;
            w_poll  = 8'd0;
          end else begin
            w_cnt   = w_cnt_nx;
            w_wdata = w_next_byte;
            if (w_cnt_nx < 3'(CMD_LEN - 1))
              w_crc = w_crc_step;
          end
        end else if (!r_req) begin
          w_req = 1'b1;
        end
      end
      POLL: begin
        if (w_ack) begin
          w_req = 1'b0;
          if (!byte_rdata[7]) begin
            w_r1    = byte_rdata;
            w_state = w_post;
            w_trail = 4'd0;
          end else if (r_poll == 8'(POLL_MAX - 1)) begin
            w_r1    = SD_IDLE_BYTE;
            w_to    = 1'b1;
            w_state = w_post;
            w_trail = 4'd0;
          end else begin
            w_poll = r_poll + 8'd1;
          end
        end else if (!r_req) begin
          w_req = 1'b1;
        end
      end
      TRAIL: begin
        if (w_ack) begin
          w_req = 1'b0;
          if (r_trail == 4'(TRAIL_BYTES - 1))
            w_state = DONE;
          else
            w_trail = r_trail + 4'd1;
        end else if (!r_req) begin
          w_req = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_arg   <= '0;
      r_cnt   <= '0;
      r_crc   <= '0;
      r_poll  <= '0;
      r_trail <= '0;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_wdata <= SD_IDLE_BYTE;
      r_r1    <= SD_IDLE_BYTE;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_arg   <= w_arg;
      r_cnt   <= w_cnt;
      r_crc   <= w_crc;
      r_poll  <= w_poll;
      r_trail <= w_trail;
      r_req   <= w_req;
      r_wr    <= w_wr;
      r_wdata <= w_wdata;
      r_r1    <= w_r1;
      r_to    <= w_to;
    end
  end

  assign busy = (r_state == SEND) ||
    (r_state == POLL) || (r_state == TRAIL);
  assign cs_n         = !busy;
  assign resp_valid   = (r_state == DONE);
  assign resp_r1      = r_r1;
  assign resp_timeout = r_to;
  assign byte_req     = r_req;
  assign byte_wr      = r_wr;
  assign byte_wdata   = r_wdata;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer.
// Engine model with random latency; frame/R1 model; per-cycle rules.
module tb_sd_cmd_sequencer;

  localparam int PM = 8;
  localparam int TB = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        busy, resp_valid, resp_timeout, cs_n;
  logic        byte_req, byte_wr;
  logic [7:0]  resp_r1, byte_wdata;
  logic        byte_ack = 1'b0;
  logic [7:0]  byte_rdata = 8'h00;

  int errors = 0;
  int checks = 0;

  logic [8:0] txq[$];
  logic [7:0] rq[$];
  logic [7:0] plan[$];
  int lat_max = 0;
  bit stray = 0;
  bit en = 0;

  always #5 clk = ~clk;

  sd_cmd_sequencer #(.POLL_MAX(PM), .TRAIL_BYTES(TB)) dut (
    .clk(clk), .reset(reset),
    .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .busy(busy),
    .resp_valid(resp_valid), .resp_r1(resp_r1),
    .resp_timeout(resp_timeout), .cs_n(cs_n),
    .byte_req(byte_req), .byte_wr(byte_wr),
    .byte_wdata(byte_wdata), .byte_ack(byte_ack),
    .byte_rdata(byte_rdata)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] crc7_bits(input logic [39:0] m);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ m[i];
      c = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // SPI byte engine: acks each request after 0..lat_max cycles.
  initial begin
    int w;
    bit armed;
    armed = 0;
    w = 0;
    forever begin
      @(negedge clk);
      byte_ack = 1'b0;
      byte_rdata = 8'h00;
      if (reset) begin
        armed = 0;
      end else if (byte_req) begin
        if (!armed) begin
          armed = 1;
          w = $urandom_range(0, lat_max);
        end
        if (w == 0) begin
          armed = 0;
          byte_ack = 1'b1;
          txq.push_back({byte_wr, byte_wdata});
          if (!byte_wr) begin
            if (rq.size() > 0) byte_rdata = rq.pop_front();
            else byte_rdata = 8'hFF;
          end
        end else begin
          w--;
        end
      end else if (stray && $urandom_range(0, 2) == 0) begin
        byte_ack = 1'b1;
        byte_rdata = 8'h00;
      end
    end
  end

  // Per-cycle handshake and framing rules.
  initial begin
    logic p_req, p_wr, p_valid, ack_e;
    logic [7:0] p_wd;
    p_req = 0; p_wr = 0; p_valid = 0; p_wd = 8'hFF;
    forever begin
      @(posedge clk);
      #1;
      if (en && !reset) begin
        ack_e = byte_ack && p_req;
        if (p_req && ack_e) begin
          chk("req_drop", byte_req, 0);
        end else if (p_req) begin
          chk("req_hold", byte_req, 1);
          chk("wr_hold", byte_wr, p_wr);
          chk("wd_hold", byte_wdata, p_wd);
        end
        if (busy && !byte_req) chk("gap_one", ack_e, 1);
        if (!busy) chk("req_idle", byte_req, 0);
        chk("cs_busy", cs_n, !busy);
        if (p_valid) chk("valid_pulse", resp_valid, 0);
        if (resp_valid) chk("valid_nbusy", busy, 0);
      end
      p_req = byte_req;
      p_wr = byte_wr;
      p_wd = byte_wdata;
      p_valid = resp_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  task automatic start_cmd(input logic [5:0] idx,
                           input logic [31:0] arg);
    @(negedge clk);
    rq = plan;
    cmd_index = idx;
    cmd_arg = arg;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cmd_index = ~idx;
    cmd_arg = ~arg;
    chk("st_busy", busy, 1);
    chk("st_cs", cs_n, 0);
    chk("st_req", byte_req, 1);
    chk("st_wr", byte_wr, 1);
    chk("st_wd", byte_wdata, {2'b01, idx});
    chk("st_to", resp_timeout, 0);
  endtask

  task automatic finish_cmd(input string tag,
                            input logic [5:0] idx,
                            input logic [31:0] arg,
                            input bit chain,
                            input logic [5:0] nidx,
                            input logic [31:0] narg,
                            output int nreads,
                            output logic [7:0] b5);
    logic [7:0] e[6];
    logic [8:0] ex;
    logic [7:0] er1, b;
    logic eto;
    int np, n;
    nreads = 0;
    b5 = 8'h00;
    n = 0;
    while (!resp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_resp_wait"}, resp_valid, 1);
    if (!resp_valid) return;
    e[0] = {2'b01, idx};
    e[1] = arg[31:24];
    e[2] = arg[23:16];
    e[3] = arg[15:8];
    e[4] = arg[7:0];
    e[5] = {crc7_bits({e[0], arg}), 1'b1};
    np = PM; er1 = 8'hFF; eto = 1'b1;
    for (int i = 0; i < PM; i++) begin
      b = (i < plan.size()) ? plan[i] : 8'hFF;
      if (!b[7]) begin
        np = i + 1; er1 = b; eto = 1'b0;
        break;
      end
    end
    chk({tag, "_ntx"}, txq.size(), 6 + np + TB);
    for (int i = 0; i < txq.size(); i++) begin
      ex = (i < 6) ? {1'b1, e[i]} : {1'b0, 8'hFF};
      chk($sformatf("%s_tx%0d", tag, i), txq[i], ex);
      if (!txq[i][8]) nreads++;
    end
    if (txq.size() > 5) b5 = txq[5][7:0];
    chk({tag, "_r1"}, resp_r1, er1);
    chk({tag, "_to"}, resp_timeout, eto);
    chk({tag, "_cs"}, cs_n, 1);
    chk({tag, "_busy"}, busy, 0);
    txq.delete();
    rq.delete();
    if (chain) begin
      rq = plan;
      cmd_index = nidx;
      cmd_arg = narg;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk({tag, "_ch_cs"}, cs_n, 0);
      chk({tag, "_ch_busy"}, busy, 1);
      chk({tag, "_ch_req"}, byte_req, 1);
      chk({tag, "_ch_wd"}, byte_wdata, {2'b01, nidx});
      chk({tag, "_ch_to"}, resp_timeout, 0);
    end else begin
      @(negedge clk);
      chk({tag, "_v_low"}, resp_valid, 0);
      chk({tag, "_r1_hold"}, resp_r1, er1);
      chk({tag, "_to_hold"}, resp_timeout, eto);
    end
  endtask

  initial begin
    int nr, n;
    logic [7:0] b5;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_r1", resp_r1, 8'hFF);
    chk("rst_to", resp_timeout, 0);
    chk("rst_cs", cs_n, 1);
    chk("rst_req", byte_req, 0);
    chk("rst_wr", byte_wr, 0);
    chk("rst_wd", byte_wdata, 8'hFF);
    reset = 1'b0;
    en = 1;
    chk("crc_cmd0", crc7_bits(40'h40_0000_0000), 7'h4A);
    chk("crc_cmd8", crc7_bits(40'h48_0000_01AA), 7'h43);

    lat_max = 0;
    plan = '{8'hFF, 8'h01};
    start_cmd(6'd0, 32'h0);
    finish_cmd("cmd0", 6'd0, 32'h0, 0, 6'd0, 32'h0, nr, b5);
    chk("cmd0_reads", nr, 3);
    chk("cmd0_crcbyte", b5, 8'h95);

    lat_max = 2;
    plan = '{8'h01};
    start_cmd(6'd8, 32'h1AA);
    finish_cmd("cmd8", 6'd8, 32'h1AA, 0, 6'd0, 32'h0, nr, b5);
    chk("cmd8_reads", nr, 2);
    chk("cmd8_crcbyte", b5, 8'h87);

    lat_max = 20;
    stray = 1;
    plan = '{8'hFF, 8'hFF, 8'h05};
    start_cmd(6'd17, 32'h1234_5678);
    repeat (3) @(negedge clk);
    cmd_index = 6'h11;
    cmd_arg = 32'hCAFE_F00D;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    finish_cmd("busy_ign", 6'd17, 32'h1234_5678,
               0, 6'd0, 32'h0, nr, b5);

    lat_max = 3;
    plan = '{8'hFF, 8'hFF, 8'hFF, 8'hFF,
             8'hFF, 8'hFF, 8'hFF, 8'h00};
    start_cmd(6'd55, 32'hDEAD_BEEF);
    finish_cmd("last_poll", 6'd55, 32'hDEAD_BEEF,
               1, 6'd41, 32'h4030_0000, nr, b5);
    chk("last_poll_reads", nr, 9);
    finish_cmd("chained", 6'd41, 32'h4030_0000,
               0, 6'd0, 32'h0, nr, b5);

    lat_max = 1;
    plan.delete();
    start_cmd(6'd2, 32'h0);
    finish_cmd("tmo", 6'd2, 32'h0, 0, 6'd0, 32'h0, nr, b5);
    chk("tmo_reads", nr, PM + TB);

    lat_max = 3;
    plan.delete();
    start_cmd(6'd0, 32'h0);
    n = 0;
    while (txq.size() < 8 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rp_in_poll", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rp_cs", cs_n, 1);
    chk("rp_req", byte_req, 0);
    chk("rp_busy", busy, 0);
    chk("rp_r1", resp_r1, 8'hFF);
    chk("rp_to", resp_timeout, 0);
    chk("rp_valid", resp_valid, 0);
    chk("rp_wd", byte_wdata, 8'hFF);
    reset = 1'b0;
    txq.delete();
    rq.delete();

    plan = '{8'h01};
    start_cmd(6'd0, 32'h0);
    finish_cmd("post_rst", 6'd0, 32'h0, 0, 6'd0, 32'h0, nr, b5);
    chk("post_rst_crc", b5, 8'h95);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
